clock_set_controller: RTL

//  User-input side of the clock/calendar counter: turns the raw increase/decrease/change buttons into an

---
 rtl/clock_pkg.sv | 40 ++++
 rtl/button_conditioner.sv | 44 ++++
 rtl/clock_set_controller.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared clock/calendar definitions: field widths, edit FSM states and calendar helpers.
// The counter core uses the same calendar helpers as the set controller.
package clock_pkg;

    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int DAY_W   = 5;
    localparam int MONTH_W = 4;
    localparam int YEAR_W  = 14;

    localparam logic [HOUR_W-1:0]  HOUR_MAX  = 5'd23;
    localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;
    localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
    localparam logic [MONTH_W-1:0] MONTH_MAX = 4'd12;
    localparam logic [YEAR_W-1:0]  YEAR_MAX  = 14'd9999;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        EDIT0  = 3'd1,
        EDIT1  = 3'd2,
        EDIT2  = 3'd3,
        COMMIT = 3'd4
    } state_t;

    function automatic logic is_leap(input logic [YEAR_W-1:0] year);
        return ((year % 14'd4) == 14'd0) &&
               (((year % 14'd100) != 14'd0) || ((year % 14'd400) == 14'd0));
    endfunction

    function automatic logic [DAY_W-1:0] days_in_month(input logic [MONTH_W-1:0] month,
                                                       input logic [YEAR_W-1:0]  year);
        case (month)
            4'd2:                      return is_leap(year) ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Raw pushbutton -> synchronised, debounced, single-cycle press pulse.
// Raw level must sit stable for DEBOUNCE_CYCLES synchronised samples before it is accepted.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1, sync2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            level       <= 1'b0;
            level_d     <= 1'b0;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any return to the accepted level restarts the stability count.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            level_d     <= level;
            press_pulse <= level & ~level_d;
        end
    end

endmodule

// File: rtl/clock_set_controller.sv
// Edit session for the clock/calendar counter: buttons step a shadow copy of time or date
// and a one-cycle load strobe commits it back to the counter core.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TIMEOUT_TICKS   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               mode,
    input  logic               butt_increase,
    input  logic               butt_decrease,
    input  logic               butt_change,
    input  logic [HOUR_W-1:0]  cur_hour,
    input  logic [MIN_W-1:0]   cur_min,
    input  logic [SEC_W-1:0]   cur_sec,
    input  logic [DAY_W-1:0]   cur_day,
    input  logic [MONTH_W-1:0] cur_month,
    input  logic [YEAR_W-1:0]  cur_year,
    output logic [HOUR_W-1:0]  set_hour,
    output logic [MIN_W-1:0]   set_min,
    output logic [SEC_W-1:0]   set_sec,
    output logic [DAY_W-1:0]   set_day,
    output logic [MONTH_W-1:0] set_month,
    output logic [YEAR_W-1:0]  set_year,
    output logic               load_time,
    output logic               load_date,
    output logic               edit_active,
    output logic [1:0]         edit_field
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_TICKS - 1);

    logic p_inc, p_dec, p_change;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_inc (
        .clk(clk), .rst_n(rst_n), .raw(butt_increase), .press_pulse(p_inc)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_dec (
        .clk(clk), .rst_n(rst_n), .raw(butt_decrease), .press_pulse(p_dec)
    );
    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_chg (
        .clk(clk), .rst_n(rst_n), .raw(butt_change), .press_pulse(p_change)
    );

    state_t        state, state_n;
    logic          mode_q;
    logic [TW-1:0] to_cnt;
    logic          any_press, step_up, step_dn, in_edit;
    logic          capture, adjust;
    logic [1:0]    field;

    // Change wins over inc/dec; inc and dec together cancel.
    assign any_press = p_inc | p_dec | p_change;
    assign step_up   = p_inc & ~p_dec & ~p_change;
    assign step_dn   = p_dec & ~p_inc & ~p_change;
    assign in_edit   = (state == EDIT0) || (state == EDIT1) || (state == EDIT2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        capture   = 1'b0;
        adjust    = 1'b0;
        field     = 2'd0;
        load_time = 1'b0;
        load_date = 1'b0;
        case (state)
            IDLE: begin
                if (p_change) begin
                    capture = 1'b1;
                    state_n = EDIT0;
                end
            end
            EDIT0, EDIT1, EDIT2: begin
                field = (state == EDIT0) ? 2'd0 : (state == EDIT1) ? 2'd1 : 2'd2;
                if (mode != mode_q)
                    state_n = IDLE;
                else if (p_change)
                    state_n = (state == EDIT0) ? EDIT1 : (state == EDIT1) ? EDIT2 : COMMIT;
                else if (tick_1hz && !any_press && to_cnt == TO_LAST)
                    state_n = IDLE;
                else
                    adjust = step_up | step_dn;
            end
            COMMIT: begin
                load_time = ~mode_q;
                load_date = mode_q;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign edit_active = in_edit;
    assign edit_field  = field;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    to_cnt <= '0;
        else if (!in_edit || any_press) to_cnt <= '0;
        else if (tick_1hz)             to_cnt <= to_cnt + 1'b1;
    end

    logic [HOUR_W-1:0]  hour_n;
    logic [MIN_W-1:0]   min_n;
    logic [SEC_W-1:0]   sec_n;
    logic [DAY_W-1:0]   day_n, dim;
    logic [MONTH_W-1:0] month_n;
    logic [YEAR_W-1:0]  year_n;

    always_comb begin
        hour_n  = set_hour;
        min_n   = set_min;
        sec_n   = set_sec;
        day_n   = set_day;
        month_n = set_month;
        year_n  = set_year;
        dim     = days_in_month(set_month, set_year);
        if (capture) begin
            hour_n  = cur_hour;
            min_n   = cur_min;
            sec_n   = cur_sec;
            day_n   = cur_day;
            month_n = cur_month;
            year_n  = cur_year;
        end else if (adjust && !mode_q) begin
            case (field)
                2'd0: hour_n = step_up ? ((set_hour >= HOUR_MAX) ? 5'd0 : set_hour + 5'd1)
                                       : ((set_hour == 5'd0) ? HOUR_MAX : set_hour - 5'd1);
                2'd1: min_n  = step_up ? ((set_min >= MIN_MAX) ? 6'd0 : set_min + 6'd1)
                                       : ((set_min == 6'd0) ? MIN_MAX : set_min - 6'd1);
                default: sec_n = step_up ? ((set_sec >= SEC_MAX) ? 6'd0 : set_sec + 6'd1)
                                         : ((set_sec == 6'd0) ? SEC_MAX : set_sec - 6'd1);
            endcase
        end else if (adjust) begin
            case (field)
                2'd0: day_n = step_up ? ((set_day >= dim) ? 5'd1 : set_day + 5'd1)
                                      : ((set_day <= 5'd1) ? dim : set_day - 5'd1);
                2'd1: begin
                    month_n = step_up ? ((set_month >= MONTH_MAX) ? 4'd1 : set_month + 4'd1)
                                      : ((set_month <= 4'd1) ? MONTH_MAX : set_month - 4'd1);
                    dim     = days_in_month(month_n, set_year);
                    if (set_day > dim) day_n = dim;
                end
                default: begin
                    year_n = step_up ? ((set_year >= YEAR_MAX) ? 14'd0 : set_year + 14'd1)
                                     : ((set_year == 14'd0) ? YEAR_MAX : set_year - 14'd1);
                    dim    = days_in_month(set_month, year_n);
                    if (set_day > dim) day_n = dim;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_hour  <= '0;
            set_min   <= '0;
            set_sec   <= '0;
            set_day   <= '0;
            set_month <= '0;
            set_year  <= '0;
            mode_q    <= 1'b0;
        end else begin
            set_hour  <= hour_n;
            set_min   <= min_n;
            set_sec   <= sec_n;
            set_day   <= day_n;
            set_month <= month_n;
            set_year  <= year_n;
            if (capture) mode_q <= mode;
        end
    end

endmodule
